// File: rtl/decode_regfile_scoreboard_pkg.sv
// Shared sizing for the decode-stage scalar/vector register files and scoreboard.
package decode_regfile_scoreboard_pkg;
  localparam int REG_WIDTH      = 16;
  localparam int VREG_WIDTH     = 64;
  localparam int NUM_SREGS      = 16;
  localparam int NUM_VREGS      = 64;
  localparam int SREG_IDX_WIDTH = 4;
  localparam int VREG_IDX_WIDTH = 6;
endpackage

// File: rtl/decode_regfile_scoreboard_regfile_bank.sv
// Register bank: one write port, two combinational read ports with write-through bypass.
module regfile_bank #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16,
  parameter int IDXW  = $clog2(DEPTH)
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic             we,
  input  logic [IDXW-1:0]  wIdx,
  input  logic [WIDTH-1:0] wData,
  input  logic [IDXW-1:0]  rIdx1,
  input  logic [IDXW-1:0]  rIdx2,
  output logic [WIDTH-1:0] rData1,
  output logic [WIDTH-1:0] rData2
);
  logic [DEPTH-1:0][WIDTH-1:0] mem;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)  mem <= '0;
    else if (we)  mem[wIdx] <= wData;
  end

  assign rData1 = (we && wIdx == rIdx1) ? wData : mem[rIdx1];
  assign rData2 = (we && wIdx == rIdx2) ? wData : mem[rIdx2];
endmodule

// File: rtl/decode_regfile_scoreboard.sv
// Decode-stage scalar/vector register files with busy-bit scoreboard and dependency stall.
import decode_regfile_scoreboard_pkg::*;

module decode_regfile_scoreboard (
  input  logic                      I_CLOCK,
  input  logic                      I_RESET_N,
  input  logic                      I_Flush,
  input  logic                      I_SrcValid,
  input  logic [SREG_IDX_WIDTH-1:0] I_SrcIdx1,
  input  logic [SREG_IDX_WIDTH-1:0] I_SrcIdx2,
  input  logic                      I_SrcUse1,
  input  logic                      I_SrcUse2,
  input  logic [VREG_IDX_WIDTH-1:0] I_VSrcIdx1,
  input  logic [VREG_IDX_WIDTH-1:0] I_VSrcIdx2,
  input  logic                      I_VSrcUse1,
  input  logic                      I_VSrcUse2,
  input  logic [VREG_IDX_WIDTH-1:0] I_DestIdx,
  input  logic                      I_DestWrites,
  input  logic                      I_DestIsVector,
  input  logic                      I_WriteBackEnable,
  input  logic                      I_VWriteBackEnable,
  input  logic [VREG_IDX_WIDTH-1:0] I_WriteBackRegIdx,
  input  logic [REG_WIDTH-1:0]      I_WriteBackData,
  input  logic [VREG_WIDTH-1:0]     I_VWriteBackData,
  output logic [REG_WIDTH-1:0]      O_SrcData1,
  output logic [REG_WIDTH-1:0]      O_SrcData2,
  output logic [VREG_WIDTH-1:0]     O_VSrcData1,
  output logic [VREG_WIDTH-1:0]     O_VSrcData2,
  output logic                      O_DepStall,
  output logic                      O_Issue
);
  // Vector write wins a same-cycle collision: the scalar write is dropped entirely.
  logic sWe, vWe;
  assign vWe = I_VWriteBackEnable;
  assign sWe = I_WriteBackEnable & ~I_VWriteBackEnable;

  logic [SREG_IDX_WIDTH-1:0] sWbIdx, sDestIdx;
  assign sWbIdx   = I_WriteBackRegIdx[SREG_IDX_WIDTH-1:0];
  assign sDestIdx = I_DestIdx[SREG_IDX_WIDTH-1:0];

  logic [REG_WIDTH-1:0]  sRd1, sRd2;
  logic [VREG_WIDTH-1:0] vRd1, vRd2;

  regfile_bank #(.DEPTH(NUM_SREGS), .WIDTH(REG_WIDTH), .IDXW(SREG_IDX_WIDTH)) uSBank (
    .gclk(I_CLOCK), .grst_n(I_RESET_N), .we(sWe), .wIdx(sWbIdx), .wData(I_WriteBackData),
    .rIdx1(I_SrcIdx1), .rIdx2(I_SrcIdx2), .rData1(sRd1), .rData2(sRd2)
  );

  regfile_bank #(.DEPTH(NUM_VREGS), .WIDTH(VREG_WIDTH), .IDXW(VREG_IDX_WIDTH)) uVBank (
    .gclk(I_CLOCK), .grst_n(I_RESET_N), .we(vWe), .wIdx(I_WriteBackRegIdx), .wData(I_VWriteBackData),
    .rIdx1(I_VSrcIdx1), .rIdx2(I_VSrcIdx2), .rData1(vRd1), .rData2(vRd2)
  );

  logic [NUM_SREGS-1:0] sBusy, sWbMask, sEff, sSet;
  logic [NUM_VREGS-1:0] vBusy, vWbMask, vEff, vSet;

  // A landing writeback hides busy in the same cycle so stall agrees with the bypass.
  assign sWbMask = sWe ? (NUM_SREGS'(1) << sWbIdx) : '0;
  assign vWbMask = vWe ? (NUM_VREGS'(1) << I_WriteBackRegIdx) : '0;
  assign sEff    = sBusy & ~sWbMask;
  assign vEff    = vBusy & ~vWbMask;

  logic srcBusy, destBusy, depStall, issue;
  assign srcBusy  = (I_SrcUse1 & sEff[I_SrcIdx1]) | (I_SrcUse2 & sEff[I_SrcIdx2]) |
                    (I_VSrcUse1 & vEff[I_VSrcIdx1]) | (I_VSrcUse2 & vEff[I_VSrcIdx2]);
  assign destBusy = I_DestIsVector ? vEff[I_DestIdx] : sEff[sDestIdx];
  assign depStall = I_SrcValid & (srcBusy | (I_DestWrites & destBusy));
  assign issue    = I_SrcValid & ~depStall & ~I_Flush;

  assign sSet = (issue & I_DestWrites & ~I_DestIsVector) ? (NUM_SREGS'(1) << sDestIdx) : '0;
  assign vSet = (issue & I_DestWrites &  I_DestIsVector) ? (NUM_VREGS'(1) << I_DestIdx) : '0;

  // Set after clear: a new claim outlives the writeback of the previous producer.
  always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      sBusy <= '0;
      vBusy <= '0;
    end else if (I_Flush) begin
      sBusy <= '0;
      vBusy <= '0;
    end else begin
      sBusy <= (sBusy & ~sWbMask) | sSet;
      vBusy <= (vBusy & ~vWbMask) | vSet;
    end
  end

  assign O_SrcData1  = I_RESET_N ? sRd1 : '0;
  assign O_SrcData2  = I_RESET_N ? sRd2 : '0;
  assign O_VSrcData1 = I_RESET_N ? vRd1 : '0;
  assign O_VSrcData2 = I_RESET_N ? vRd2 : '0;
  assign O_DepStall  = I_RESET_N & depStall;
  assign O_Issue     = I_RESET_N & issue;

  wbPortsExclusive: assert property (@(posedge I_CLOCK) disable iff (!I_RESET_N)
    !(I_WriteBackEnable && I_VWriteBackEnable));
endmodule

// File: tb/tb_decode_regfile_scoreboard.sv
// Directed bench for the decode register files and scoreboard, queue-based expectations.
module tb_decode_regfile_scoreboard;
  logic        clk = 1'b0;
  logic        rstN;
  logic        flush, srcValid, srcUse1, srcUse2, vSrcUse1, vSrcUse2;
  logic [3:0]  srcIdx1, srcIdx2;
  logic [5:0]  vSrcIdx1, vSrcIdx2, destIdx, wbIdx;
  logic        destWrites, destIsVector, wbEn, vWbEn;
  logic [15:0] wbData;
  logic [63:0] vWbData;
  logic [15:0] srcData1, srcData2;
  logic [63:0] vSrcData1, vSrcData2;
  logic        depStall, issueOut;

  always #5 clk = ~clk;

  decode_regfile_scoreboard dut (
    .I_CLOCK(clk), .I_RESET_N(rstN), .I_Flush(flush), .I_SrcValid(srcValid),
    .I_SrcIdx1(srcIdx1), .I_SrcIdx2(srcIdx2), .I_SrcUse1(srcUse1), .I_SrcUse2(srcUse2),
    .I_VSrcIdx1(vSrcIdx1), .I_VSrcIdx2(vSrcIdx2), .I_VSrcUse1(vSrcUse1), .I_VSrcUse2(vSrcUse2),
    .I_DestIdx(destIdx), .I_DestWrites(destWrites), .I_DestIsVector(destIsVector),
    .I_WriteBackEnable(wbEn), .I_VWriteBackEnable(vWbEn), .I_WriteBackRegIdx(wbIdx),
    .I_WriteBackData(wbData), .I_VWriteBackData(vWbData),
    .O_SrcData1(srcData1), .O_SrcData2(srcData2), .O_VSrcData1(vSrcData1), .O_VSrcData2(vSrcData2),
    .O_DepStall(depStall), .O_Issue(issueOut)
  );

  localparam int S1 = 0, S2 = 1, V1 = 2, V2 = 3, ST = 4, IS = 5;

  typedef struct {
    string       tag;
    int          sel;
    logic [63:0] exp;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [63:0] obs(int sel);
    case (sel)
      S1:      return {48'h0, srcData1};
      S2:      return {48'h0, srcData2};
      V1:      return vSrcData1;
      V2:      return vSrcData2;
      ST:      return {63'h0, depStall};
      default: return {63'h0, issueOut};
    endcase
  endfunction

  task automatic pushExp(string tag, int sel, logic [63:0] v);
    exp_t e;
    e.tag = tag; e.sel = sel; e.exp = v;
    q.push_back(e);
  endtask

  // Outputs are combinational: compare on the falling edge, then advance past the rising edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      assert (obs(e.sel) === e.exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs(e.sel), e.exp);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clearIn();
    flush = 0; srcValid = 0; srcUse1 = 0; srcUse2 = 0; vSrcUse1 = 0; vSrcUse2 = 0;
    srcIdx1 = 0; srcIdx2 = 0; vSrcIdx1 = 0; vSrcIdx2 = 0; destIdx = 0;
    destWrites = 0; destIsVector = 0; wbEn = 0; vWbEn = 0; wbIdx = 0;
    wbData = 0; vWbData = 0;
  endtask

  task automatic issueDest(logic [5:0] d, logic isVec, string tag);
    clearIn();
    srcValid = 1; destWrites = 1; destIdx = d; destIsVector = isVec;
    pushExp({tag, "_issue"}, IS, 1); pushExp({tag, "_stall"}, ST, 0);
    step();
  endtask

  localparam logic [63:0] VA = 64'h0001_0002_0003_0004;
  localparam logic [63:0] VB = 64'hDEAD_BEEF_CAFE_F00D;
  localparam logic [63:0] VC = 64'h1111_2222_3333_4444;

  initial begin
    clearIn();
    rstN = 0;
    #2;
    // Inside reset: reads forced to 0, no stall, no issue, even with a bypass candidate.
    srcValid = 1; srcIdx1 = 3; vSrcIdx1 = 10; destWrites = 1; destIdx = 3;
    wbEn = 1; wbIdx = 3; wbData = 16'hFFFF;
    pushExp("rst_s1", S1, 0); pushExp("rst_v1", V1, 0);
    pushExp("rst_stall", ST, 0); pushExp("rst_issue", IS, 0);
    step();
    rstN = 1;

    clearIn();
    srcValid = 1; srcIdx1 = 3; srcUse1 = 1; vSrcIdx1 = 10; vSrcUse1 = 1;
    pushExp("init_s3", S1, 0); pushExp("init_v10", V1, 0); pushExp("init_stall", ST, 0);
    step();

    issueDest(6'd5, 0, "add_s5");

    clearIn();
    srcValid = 1; srcIdx1 = 5; srcUse1 = 1;
    pushExp("raw_s5_stall", ST, 1); pushExp("raw_s5_issue", IS, 0);
    step();

    clearIn();
    srcValid = 1; srcIdx1 = 5; srcUse1 = 1; wbEn = 1; wbIdx = 5; wbData = 16'h1234;
    pushExp("wb_s5_stall", ST, 0); pushExp("wb_s5_bypass", S1, 16'h1234); pushExp("wb_s5_issue", IS, 1);
    step();

    clearIn();
    srcValid = 1; srcIdx1 = 5; srcUse1 = 1;
    pushExp("s5_stored", S1, 16'h1234); pushExp("s5_free", ST, 0);
    step();

    issueDest(6'd40, 1, "vadd_v40");

    // Writeback of V40 and a new claim on V40 in the same cycle.
    clearIn();
    srcValid = 1; destWrites = 1; destIsVector = 1; destIdx = 40; vSrcIdx1 = 40;
    vWbEn = 1; wbIdx = 40; vWbData = VA;
    pushExp("setwins_issue", IS, 1); pushExp("setwins_stall", ST, 0); pushExp("v40_bypass", V1, VA);
    step();

    clearIn();
    srcValid = 1; vSrcIdx1 = 40; vSrcUse1 = 1;
    pushExp("v40_still_busy", ST, 1); pushExp("v40_stored", V1, VA); pushExp("v40_issue", IS, 0);
    step();

    clearIn();
    vSrcIdx1 = 40; vWbEn = 1; wbIdx = 40; vWbData = VB;
    pushExp("novalid_stall", ST, 0); pushExp("novalid_issue", IS, 0); pushExp("v40_bypass2", V1, VB);
    step();

    issueDest(6'd7, 0, "dst_s7");

    clearIn();
    srcValid = 1; destWrites = 1; destIdx = 7;
    pushExp("waw_stall", ST, 1); pushExp("waw_issue", IS, 0);
    step();

    issueDest(6'd1, 0, "dst_s1");
    issueDest(6'd2, 1, "dst_v2");

    clearIn();
    flush = 1; srcValid = 1; destWrites = 1; destIdx = 9;
    pushExp("flush_stall", ST, 0); pushExp("flush_issue", IS, 0);
    step();

    clearIn();
    srcValid = 1; srcIdx1 = 1; srcUse1 = 1; srcIdx2 = 5; srcUse2 = 1;
    vSrcIdx1 = 2; vSrcUse1 = 1; vSrcIdx2 = 40; vSrcUse2 = 1; destWrites = 1; destIdx = 7;
    pushExp("postflush_stall", ST, 0); pushExp("postflush_issue", IS, 1);
    pushExp("postflush_s1", S1, 0); pushExp("postflush_s5", S2, 16'h1234);
    pushExp("postflush_v2", V1, 0); pushExp("postflush_v40", V2, VB);
    step();

    clearIn();
    srcValid = 1; srcIdx1 = 9; srcUse1 = 1;
    pushExp("s9_not_claimed", ST, 0);
    step();

    // Scalar write with upper index bits set must not touch the vector file.
    clearIn();
    srcIdx1 = 3; vSrcIdx1 = 35; wbEn = 1; wbIdx = 6'h23; wbData = 16'hBEEF;
    pushExp("s3_alias_bypass", S1, 16'hBEEF); pushExp("v35_no_bypass", V1, 0);
    step();

    clearIn();
    srcValid = 1; srcIdx1 = 3; srcUse1 = 1; vSrcIdx1 = 35; vSrcUse1 = 1;
    pushExp("s3_alias_stored", S1, 16'hBEEF); pushExp("v35_unchanged", V1, 0); pushExp("alias_stall", ST, 0);
    step();

    clearIn();
    wbEn = 1; wbIdx = 10; wbData = 16'h0A0A;
    pushExp("idle_issue", IS, 0);
    step();

    clearIn();
    srcValid = 1; srcIdx2 = 10; srcUse2 = 1;
    pushExp("s10_stored", S2, 16'h0A0A); pushExp("s10_free", ST, 0);
    step();

    issueDest(6'd4, 0, "dst_s4");

    // A vector writeback to index 4 must not clear scalar S4.
    clearIn();
    srcValid = 1; srcIdx1 = 4; srcUse1 = 1; vSrcIdx1 = 4; vWbEn = 1; wbIdx = 4; vWbData = VC;
    pushExp("xclass_stall", ST, 1); pushExp("xclass_s4", S1, 0); pushExp("xclass_v4", V1, VC);
    step();

    clearIn();
    srcValid = 1; srcIdx1 = 4; srcUse1 = 1; wbEn = 1; wbIdx = 4; wbData = 16'h4444;
    pushExp("s4_wb_stall", ST, 0); pushExp("s4_wb_bypass", S1, 16'h4444); pushExp("s4_wb_issue", IS, 1);
    step();

    issueDest(6'd6, 0, "dst_s6");

    rstN = 0;
    #2;
    rstN = 1;
    clearIn();
    srcValid = 1; srcIdx1 = 6; srcUse1 = 1; srcIdx2 = 5; srcUse2 = 1;
    destWrites = 1; destIdx = 7; vSrcIdx1 = 40;
    pushExp("postrst_stall", ST, 0); pushExp("postrst_issue", IS, 1);
    pushExp("postrst_s5", S2, 0); pushExp("postrst_v40", V1, 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
